// File: rtl/fbuf_pkg.sv
// Shared types and helpers for the VGA frame buffer.
// Optional build macro: FBUF_DOUBLE_BUF_EN (two banks with frame-synchronous swap).
package fbuf_pkg;

    // Stored pixel is RGB444.
    localparam int PIX_BITS = 12;

    // Saturation ceiling of the dropped-write counter.
    localparam logic [15:0] WR_DROP_MAX = 16'hFFFF;

    typedef logic [PIX_BITS-1:0] pix_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Widen each 4-bit channel to 8 bits by repeating the nibble (0xA -> 0xAA),
    // so full-scale 0xF maps to 0xFF and 0x0 stays 0x00.
    function automatic logic [23:0] rgb444_to_888(input pix_t p);
        return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
    endfunction

endpackage

// File: rtl/fbuf_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// A read and a write to the same address on the same edge return the old word.
module fbuf_ram
    import fbuf_pkg::*;
#(
    parameter int DEPTH = 768,
    parameter int WIDTH = PIX_BITS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read port; samples the pre-write contents.
    always_ff @(posedge clk) begin
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/vga_fbuf.sv
// Writable, down-scaled frame buffer feeding vga_ctrl. Stores RGB444, serves
// RGB888 one cycle after h_addr/v_addr. Has a valid/ready pixel write port and
// a hardware clear engine that fills the (back) buffer one word per cycle.
// Optional build macro: FBUF_DOUBLE_BUF_EN -- two banks, display reads the
// front bank, writes/clears go to the back bank, swap taken on frame_start.
module vga_fbuf
    import fbuf_pkg::*;
#(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int SCALE_SHIFT = 1,
    parameter int PIX_W       = PIX_BITS
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [9:0]       h_addr,
    input  logic [9:0]       v_addr,
    input  logic             rd_en,
    input  logic             frame_start,
    output logic [23:0]      vga_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [9:0]       wr_x,
    input  logic [9:0]       wr_y,
    input  logic [PIX_W-1:0] wr_pix,
    input  logic             clr_start,
    input  logic [PIX_W-1:0] clr_color,
    output logic             busy,
    output logic [15:0]      wr_drop,
    input  logic             swap_req,
    output logic             swap_pending
);

    localparam int FB_W  = H_RES >> SCALE_SHIFT;
    localparam int FB_H  = V_RES >> SCALE_SHIFT;
    localparam int DEPTH = FB_W * FB_H;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] FB_W_A    = AW'(FB_W);
    // 11-bit limits so a 10-bit coordinate can be compared against 1024.
    localparam logic [10:0]   H_LIM     = 11'(H_RES);
    localparam logic [10:0]   V_LIM     = 11'(V_RES);
    localparam logic [10:0]   FBW_LIM   = 11'(FB_W);
    localparam logic [10:0]   FBH_LIM   = 11'(FB_H);

    state_e           state_q, state_d;
    logic [AW-1:0]    clr_addr_q, clr_addr_d;
    logic [PIX_W-1:0] clr_color_q, clr_color_d;
    logic [15:0]      wr_drop_q, wr_drop_d;
    logic             rd_ok_q, rd_ok_d;

    logic             wr_acc;
    logic             wr_in_range;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [PIX_W-1:0] ram_wdata;
    logic [AW-1:0]    ram_raddr;
    logic [PIX_W-1:0] rd_pix;

    // Display address: linear index into the scaled image, zero when off-screen.
    always_comb begin
        rd_ok_d   = rd_en && ({1'b0, h_addr} < H_LIM) && ({1'b0, v_addr} < V_LIM);
        ram_raddr = '0;
        if (rd_ok_d) begin
            ram_raddr = AW'(v_addr >> SCALE_SHIFT) * FB_W_A + AW'(h_addr >> SCALE_SHIFT);
        end
    end

    // Clear engine: IDLE waits for clr_start, CLEAR walks every address once.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        clr_color_d = clr_color_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d     = CLEAR;
                    clr_addr_d  = '0;
                    clr_color_d = clr_color;
                end
            end
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Write port arbitration: the clear owns the RAM; a starting clear beats a write.
    always_comb begin
        wr_ready    = (state_q == IDLE) && !clr_start;
        wr_acc      = wr_valid && wr_ready;
        wr_in_range = ({1'b0, wr_x} < FBW_LIM) && ({1'b0, wr_y} < FBH_LIM);
        ram_we      = 1'b0;
        ram_waddr   = clr_addr_q;
        ram_wdata   = clr_color_q;
        if (state_q == CLEAR) begin
            ram_we = 1'b1;
        end else if (wr_acc && wr_in_range) begin
            ram_we    = 1'b1;
            ram_waddr = AW'(wr_y) * FB_W_A + AW'(wr_x);
            ram_wdata = wr_pix;
        end
        // Out-of-range writes are accepted (handshake completes) but only counted.
        wr_drop_d = wr_drop_q;
        if (wr_acc && !wr_in_range && (wr_drop_q != WR_DROP_MAX)) begin
            wr_drop_d = wr_drop_q + 16'd1;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            clr_addr_q  <= '0;
            clr_color_q <= '0;
            wr_drop_q   <= '0;
            rd_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            clr_color_q <= clr_color_d;
            wr_drop_q   <= wr_drop_d;
            rd_ok_q     <= rd_ok_d;
        end
    end

`ifdef FBUF_DOUBLE_BUF_EN
    logic                  front_q, front_d;
    logic                  pend_q, pend_d;
    logic                  rd_bank_q;
    logic [1:0][PIX_W-1:0] bank_rdata;

    // Swap bookkeeping: a request waits for frame_start, and for any clear to finish.
    always_comb begin
        pend_d  = pend_q | swap_req;
        front_d = front_q;
        if (frame_start && pend_d && (state_q == IDLE)) begin
            front_d = ~front_q;
            pend_d  = 1'b0;
        end
    end

    // Bank state; rd_bank_q remembers which bank the in-flight read came from.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            front_q   <= 1'b0;
            pend_q    <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            front_q   <= front_d;
            pend_q    <= pend_d;
            rd_bank_q <= front_q;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fbuf_ram #(.DEPTH(DEPTH), .WIDTH(PIX_W), .AW(AW)) u_ram (
            .clk   (clk),
            .we    (ram_we && (front_q == 1'(1 - b))),
            .waddr (ram_waddr),
            .wdata (ram_wdata),
            .raddr (ram_raddr),
            .rdata (bank_rdata[b])
        );
    end

    assign rd_pix       = bank_rdata[rd_bank_q];
    assign swap_pending = pend_q;
`else
    logic unused_swap;

    fbuf_ram #(.DEPTH(DEPTH), .WIDTH(PIX_W), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (rd_pix)
    );

    assign unused_swap  = ^{swap_req, frame_start};
    assign swap_pending = 1'b0;
`endif

    assign vga_data = rd_ok_q ? rgb444_to_888(pix_t'(rd_pix)) : 24'h000000;
    assign busy     = (state_q == CLEAR);
    assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_vga_fbuf.sv
// Directed self-checking bench for vga_fbuf. Uses a reduced 64x48 display
// (stored 32x24, 768 words) so a full clear and counter saturation stay short.
// With FBUF_DOUBLE_BUF_EN defined the bank/swap sequence replaces the
// single-bank sequence; reset and counter checks are common.
module tb_vga_fbuf;

    localparam int CLR_LEN = 32 * 24;

    logic        clk = 1'b0;
    logic        resetn;
    logic [9:0]  h_addr, v_addr, wr_x, wr_y;
    logic        rd_en, frame_start, wr_valid, clr_start, swap_req;
    logic [11:0] wr_pix, clr_color;
    logic [23:0] vga_data;
    logic        wr_ready, busy, swap_pending;
    logic [15:0] wr_drop;

    int n_chk  = 0;
    int n_fail = 0;

    vga_fbuf #(.H_RES(64), .V_RES(48), .SCALE_SHIFT(1), .PIX_W(12)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .h_addr       (h_addr),
        .v_addr       (v_addr),
        .rd_en        (rd_en),
        .frame_start  (frame_start),
        .vga_data     (vga_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_pix       (wr_pix),
        .clr_start    (clr_start),
        .clr_color    (clr_color),
        .busy         (busy),
        .wr_drop      (wr_drop),
        .swap_req     (swap_req),
        .swap_pending (swap_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a display address, then check the pixel one cycle later.
    task automatic rd_chk(input string tag, input int h, input int v, input logic [23:0] exp);
        h_addr = 10'(h);
        v_addr = 10'(v);
        rd_en  = 1'b1;
        tick();
        chk(tag, {8'h0, vga_data}, {8'h0, exp});
    endtask

    task automatic wr(input int x, input int y, input logic [11:0] pix);
        wr_x     = 10'(x);
        wr_y     = 10'(y);
        wr_pix   = pix;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    // Pulse clr_start and wait (bounded) for busy to fall; returns busy cycles.
    task automatic do_clear(input logic [11:0] col, output int n);
        clr_color = col;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        n = 0;
        while (busy && n < 5000) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n, bad;
        resetn = 1'b0; h_addr = '0; v_addr = '0; rd_en = 1'b0; frame_start = 1'b0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_pix = '0; clr_start = 1'b0;
        clr_color = '0; swap_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vga", {8'h0, vga_data}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_drop", {16'h0, wr_drop}, 32'h0);
        chk("rst_pend", {31'h0, swap_pending}, 32'h0);
        chk("rst_ready", {31'h0, wr_ready}, 32'h1);
        @(negedge clk);
        resetn = 1'b1;
        tick();

`ifndef FBUF_DOUBLE_BUF_EN
        // Basic write, 2x replication on readback.
        wr(5, 3, 12'hF80);
        rd_chk("rd_10_6", 10, 6, 24'hFF8800);
        rd_chk("rd_11_6", 11, 6, 24'hFF8800);
        rd_chk("rd_10_7", 10, 7, 24'hFF8800);
        rd_chk("rd_11_7", 11, 7, 24'hFF8800);

        // Blanking: rd_en low, h/v at the limit.
        h_addr = 10; v_addr = 6; rd_en = 1'b0;
        tick();
        chk("rd_en0", {8'h0, vga_data}, 32'h0);
        rd_chk("rd_h_lim", 64, 6, 24'h000000);
        rd_chk("rd_v_lim", 10, 48, 24'h000000);
        rd_chk("rd_back", 10, 6, 24'hFF8800);

        // Full clear: length, stalled writes, a second clr_start ignored.
        clr_color = 12'h00F;
        clr_start = 1'b1;
        #1;
        chk("clr_ready0", {31'h0, wr_ready}, 32'h0);
        tick();
        clr_start = 1'b0;
        n = 0; bad = 0;
        while (busy && n < 5000) begin
            if (wr_ready) bad++;
            clr_start = (n == 10);
            clr_color = (n == 10) ? 12'hF00 : 12'h00F;
            n++;
            tick();
        end
        clr_start = 1'b0;
        chk("clr_len", n, CLR_LEN);
        chk("clr_stall", bad, 0);
        chk("clr_ready1", {31'h0, wr_ready}, 32'h1);
        rd_chk("clr_0_0", 0, 0, 24'h0000FF);
        rd_chk("clr_63_47", 63, 47, 24'h0000FF);
        rd_chk("clr_11_7", 11, 7, 24'h0000FF);

        // Read and write of the same word on one edge returns old data.
        h_addr = 2; v_addr = 2; rd_en = 1'b1;
        wr(1, 1, 12'h123);
        chk("col_old", {8'h0, vga_data}, 32'h0000FF);
        rd_chk("col_new", 2, 2, 24'h112233);

        // Out-of-range x is accepted, counted, and must not alias to (0,1).
        wr_x = 32; wr_y = 0; wr_pix = 12'hABC; wr_valid = 1'b1;
        #1;
        chk("drop_ready", {31'h0, wr_ready}, 32'h1);
        tick();
        wr_valid = 1'b0;
        chk("drop_cnt", {16'h0, wr_drop}, 32'h1);
        rd_chk("drop_alias", 0, 2, 24'h0000FF);

        // Clear beats a simultaneous write; reset mid-clear aborts it.
        wr_x = 10; wr_y = 10; wr_pix = 12'hFFF; wr_valid = 1'b1;
        clr_color = 12'h0A0; clr_start = 1'b1;
        #1;
        chk("cw_ready", {31'h0, wr_ready}, 32'h0);
        tick();
        wr_valid = 1'b0; clr_start = 1'b0;
        chk("cw_busy", {31'h0, busy}, 32'h1);
        repeat (99) tick();
        resetn = 1'b0;
        #1;
        chk("mid_busy", {31'h0, busy}, 32'h0);
        chk("mid_ready", {31'h0, wr_ready}, 32'h1);
        chk("mid_drop", {16'h0, wr_drop}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        rd_chk("part_0_0", 0, 0, 24'h00AA00);
        rd_chk("part_2_2", 2, 2, 24'h00AA00);
        rd_chk("part_20_20", 20, 20, 24'h0000FF);
`else
        // Fill bank 1 (back) then make it the front.
        do_clear(12'h00F, n);
        chk("db_clr1_len", n, CLR_LEN);
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        chk("db_pend1", {31'h0, swap_pending}, 32'h1);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("db_pend0", {31'h0, swap_pending}, 32'h0);
        rd_chk("db_front1", 8, 8, 24'h0000FF);

        // Fill bank 0 (back); a swap requested during the clear is deferred.
        clr_color = 12'h00F; clr_start = 1'b1; tick(); clr_start = 1'b0;
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("db_defer_pend", {31'h0, swap_pending}, 32'h1);
        chk("db_defer_busy", {31'h0, busy}, 32'h1);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            tick();
        end
        chk("db_clr0_end", {31'h0, busy}, 32'h0);

        // Write to back bank is invisible until the next frame_start.
        wr(4, 4, 12'h0F0);
        rd_chk("db_old", 8, 8, 24'h0000FF);
        chk("db_pend_kept", {31'h0, swap_pending}, 32'h1);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("db_pend_clr", {31'h0, swap_pending}, 32'h0);
        rd_chk("db_new", 8, 8, 24'h00FF00);

        // swap_req together with frame_start is taken on that frame.
        swap_req = 1'b1; frame_start = 1'b1; tick();
        swap_req = 1'b0; frame_start = 1'b0;
        chk("db_coinc_pend", {31'h0, swap_pending}, 32'h0);
        rd_chk("db_coinc", 8, 8, 24'h0000FF);
`endif

        // Dropped-write counter and its saturation.
        wr(0, 24, 12'h555);
        chk("sat_first", {16'h0, wr_drop}, 32'h1);
        wr_x = 0; wr_y = 24; wr_valid = 1'b1;
        repeat (65540) tick();
        wr_valid = 1'b0;
        chk("sat_max", {16'h0, wr_drop}, 32'hFFFF);
        tick();
        chk("sat_hold", {16'h0, wr_drop}, 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fbuf.md
Name: vga_fbuf

Overview:
- Parametrised, writable frame buffer replacing the fixed read-only picture memory feeding vga_ctrl.
- Stores a down-scaled image (pixel replication by 2^SCALE_SHIFT) in compact RGB444 form and serves 24-bit RGB888 to the VGA path with fixed 1-cycle latency.
- Provides a valid/ready pixel write port for drawing logic (keyboard/UART demos) and a hardware clear engine.

Parameters:
- H_RES, 640, visible horizontal pixels driven by vga_ctrl.
- V_RES, 480, visible vertical lines.
- SCALE_SHIFT, 1, replication factor 2^SCALE_SHIFT in both axes. Stored size FB_W = H_RES>>SCALE_SHIFT, FB_H = V_RES>>SCALE_SHIFT.
- PIX_W, 12, stored pixel width (RGB444, 4 bits per channel).

Ports:
- clk  in  1  pixel clock.
- resetn  in  1  asynchronous active-low reset.
- h_addr  in  10  current display column from vga_ctrl.
- v_addr  in  10  current display line from vga_ctrl.
- rd_en  in  1  display active (vga_ctrl valid).
- frame_start  in  1  single-cycle pulse at the start of each frame.
- vga_data  out  24  RGB888 pixel, registered.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when high with wr_valid.
- wr_x  in  10  write column, stored coordinates.
- wr_y  in  10  write line, stored coordinates.
- wr_pix  in  PIX_W  write colour.
- clr_start  in  1  pulse that starts the full-buffer clear.
- clr_color  in  PIX_W  clear colour, sampled on clr_start.
- busy  out  1  clear in progress.
- wr_drop  out  16  saturating count of out-of-range writes.
- swap_req  in  1  request a buffer swap (double-buffer build only).
- swap_pending  out  1  swap requested, not yet taken.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (resetn).
- Reset values:
  - vga_data=0, busy=0, wr_drop=0, swap_pending=0.
  - FSM in IDLE; front bank = 0.
  - RAM contents are not reset.
- Read path:
  - Address = (v_addr>>SCALE_SHIFT)*FB_W + (h_addr>>SCALE_SHIFT). This is a linear address, not bit concatenation.
  - vga_data is valid on the cycle after h_addr/v_addr are presented.
  - Each 4-bit channel expands to 8 bits by nibble replication (0xA -> 0xAA).
  - If rd_en=0, h_addr>=H_RES or v_addr>=V_RES, then vga_data=0 on the next cycle.
- Write path:
  - wr_ready = (state==IDLE) && !clr_start. This is combinational.
  - A write is accepted on the edge where wr_valid && wr_ready; RAM is updated on that edge.
  - If wr_x>=FB_W or wr_y>=FB_H, the write is still accepted but dropped, and wr_drop increments (saturates at 0xFFFF).
  - A read of the same address in the same cycle returns the old data.
- FSM states:
  - IDLE: on clr_start, latch clr_color, set clr_addr=0, go to CLEAR.
  - CLEAR: write clr_color at clr_addr, one word per cycle; busy=1. At clr_addr==FB_W*FB_H-1, write the last word and return to IDLE; busy falls the following cycle.
  - A full clear takes exactly FB_W*FB_H cycles.
- Boundary conditions:
  - clr_start while in CLEAR is ignored.
  - clr_start together with wr_valid in IDLE: clear wins and the write is not accepted.
  - Writes stall (wr_ready=0) for the whole clear.
  - Reset asserted mid-clear: the FSM returns to IDLE immediately and memory is left partially cleared.
  - Display reads continue during a clear.

Optional Feature:
- Macro: FBUF_DOUBLE_BUF_EN.
- Defined:
  - Two RAM banks. Display reads the front bank; writes and clears target the back bank.
  - swap_req sets swap_pending.
  - On frame_start with swap_pending=1: front bank toggles and swap_pending clears in the same edge.
  - swap_req coincident with frame_start: the swap is taken that frame.
  - swap_req while busy stays pending and the swap is deferred until the clear finishes.
- Undefined:
  - Single bank shared by reads and writes; swap_req ignored; swap_pending tied 0.

Decomposition:
- Package fbuf_pkg holds:
  - the pixel typedef (PIX_W);
  - the state enum {IDLE, CLEAR};
  - the function expanding RGB444 to RGB888;
  - the WR_DROP_MAX constant.
- Sub-module fbuf_ram: simple dual-port synchronous RAM (one write port, one registered read port), depth FB_W*FB_H. It is instantiated once, or twice under FBUF_DOUBLE_BUF_EN.

Test Plan:
- Reset then write (x=5,y=3,pix=0xF80), with default parameters (FB_W=320) -> reading h=10..11, v=6..7 yields vga_data=0xFF8800 one cycle later at all four positions.
- Write x=320,y=0 -> wr_ready=1, write dropped, wr_drop=1; 70000 out-of-range writes -> wr_drop=0xFFFF.
- clr_start with clr_color=0x00F -> busy=1 for exactly 76800 cycles and wr_ready=0 throughout; afterwards any in-range read returns 0x0000FF.
- clr_start and wr_valid in the same cycle -> write not accepted, clear starts; resetn pulsed low at clear cycle 100 -> busy=0 and wr_ready=1 immediately.
- rd_en=0, or h_addr=640 -> vga_data=0x000000 the next cycle regardless of RAM contents.
- With FBUF_DOUBLE_BUF_EN defined:
  - write 0x0F0 to back bank -> display still shows old value;
  - swap_req -> swap_pending=1;
  - next frame_start -> display shows 0x00FF00 and swap_pending=0.
